msix_message_generator: RTL

Downstream consumer of the MSI-X capability registers. It holds the MSI-X table (per-vector address, data and mask) and the Pending Bit Array. It converts per-vector interrupt request pulses into memory-write message requests on a valid/ready interface toward the TLP transmit path, honouring MSI-X Enable, Function Mask and the per-vector masks.

---
 rtl/msix_pkg.sv | 30 +++
 rtl/msix_rr_arbiter.sv | 34 +++
 rtl/msix_message_generator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/msix_pkg.sv
// msix_pkg
//   Shared types and constants for the MSI-X message generator:
//   table DWORD selects, FSM state encoding and the table entry layout.
package msix_pkg;

    localparam logic [1:0] MSIX_DW_ADDR_LO = 2'd0;
    localparam logic [1:0] MSIX_DW_ADDR_HI = 2'd1;
    localparam logic [1:0] MSIX_DW_DATA    = 2'd2;
    localparam logic [1:0] MSIX_DW_VCTRL   = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } msix_state_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
        logic        mask;
    } msix_entry_t;

    // Entries come out of reset masked with a null address/data.
    localparam msix_entry_t MSIX_ENTRY_RESET = '{addr: 64'd0, data: 32'd0, mask: 1'b1};

    // Message addresses are DWORD aligned; the two low bits never hold state.
    function automatic logic [31:0] msix_addr_lo(input logic [31:0] wr_data);
        return {wr_data[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/msix_rr_arbiter.sv
// msix_rr_arbiter
//   Combinational round-robin arbiter. The search starts at the index after
//   last_idx and wraps, so the most recently granted vector has lowest priority.
//   Ports:
//     req      in  NUM_REQ  request vector
//     last_idx in  IDX_W    previously granted index
//     gnt_idx  out IDX_W    granted index (0 when nothing is requested)
//     gnt_any  out 1        at least one request is granted
module msix_rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    int cand;

    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_idx) + k) % NUM_REQ;
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/msix_message_generator.sv
// msix_message_generator
//   Holds the MSI-X table and Pending Bit Array and turns per-vector request
//   pulses into memory-write message requests on a valid/ready handshake.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     msix_enable         MSI-X Enable; when low the PBA is held clear
//     function_mask       Function Mask; blocks issuing, keeps pending bits
//     irq_req             one-cycle request pulse per vector
//     tbl_wr_*            table DWORD write port (idx, dword select, data)
//     pba                 Pending Bit Array
//     msg_valid/msg_ready message handshake toward the TLP transmit path
//     msg_addr/data/vec   message payload, held stable while msg_valid
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no message outstanding; grant next eligible vector, latch payload
//   ISSUE | msg_valid high, payload frozen until msg_ready
module msix_message_generator
    import msix_pkg::*;
#(
    parameter int NUM_VECTORS = 8,
    parameter int IDX_W       = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msix_enable,
    input  logic                   function_mask,
    input  logic [NUM_VECTORS-1:0] irq_req,
    input  logic                   tbl_wr_en,
    input  logic [IDX_W-1:0]       tbl_wr_idx,
    input  logic [1:0]             tbl_wr_dw,
    input  logic [31:0]            tbl_wr_data,
    output logic [NUM_VECTORS-1:0] pba,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [63:0]            msg_addr,
    output logic [31:0]            msg_data,
    output logic [IDX_W-1:0]       msg_vec
);

    msix_entry_t            tbl_q [NUM_VECTORS];
    msix_state_t            state_q;
    logic [IDX_W-1:0]       last_q;
    logic [NUM_VECTORS-1:0] mask_vec;
    logic [NUM_VECTORS-1:0] eligible;
    logic [NUM_VECTORS-1:0] pba_clr;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_any;

    // Table: equality decode per entry, so an index beyond the table matches
    // nothing and the write is silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                tbl_q[i] <= MSIX_ENTRY_RESET;
            end
        end else if (tbl_wr_en) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                if (tbl_wr_idx == IDX_W'(i)) begin
                    case (tbl_wr_dw)
                        MSIX_DW_ADDR_LO: tbl_q[i].addr[31:0]  <= msix_addr_lo(tbl_wr_data);
                        MSIX_DW_ADDR_HI: tbl_q[i].addr[63:32] <= tbl_wr_data;
                        MSIX_DW_DATA:    tbl_q[i].data        <= tbl_wr_data;
                        MSIX_DW_VCTRL:   tbl_q[i].mask        <= tbl_wr_data[0];
                        default:         ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        mask_vec = '0;
        pba_clr  = '0;
        for (int i = 0; i < NUM_VECTORS; i++) begin
            mask_vec[i] = tbl_q[i].mask;
            pba_clr[i]  = msg_valid && msg_ready && (msg_vec == IDX_W'(i));
        end
    end

    // A request arriving in the acceptance cycle wins over the clear, so the
    // vector stays pending and is issued again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pba <= '0;
        end else if (!msix_enable) begin
            pba <= '0;
        end else begin
            pba <= (pba & ~pba_clr) | irq_req;
        end
    end

    assign eligible = (msix_enable && !function_mask) ? (pba & ~mask_vec) : '0;

    msix_rr_arbiter #(
        .NUM_REQ (NUM_VECTORS),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req      (eligible),
        .last_idx (last_q),
        .gnt_idx  (gnt_idx),
        .gnt_any  (gnt_any)
    );

    // The payload is captured from the registered table, so a table write in
    // the grant cycle lands after the capture and the old contents go out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            msg_valid <= 1'b0;
            msg_addr  <= '0;
            msg_data  <= '0;
            msg_vec   <= '0;
            last_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        msg_addr  <= tbl_q[gnt_idx].addr;
                        msg_data  <= tbl_q[gnt_idx].data;
                        msg_vec   <= gnt_idx;
                        last_q    <= gnt_idx;
                        msg_valid <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (msg_ready) begin
                        msg_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    msg_valid <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
